// File: rtl/line_clear_sequencer.sv
// Removes full playfield rows through Grid_Mem port A: bottom-up scan, shift-down of rows above, zero-fill of row 0.
// Latency: 2 cycles per empty-leading row, COLS+1 per full row scan, 2*COLS per shifted row, COLS for the top fill.
// No backpressure: port A is owned outright while busy; start is dropped unless IDLE. Option: LINE_CLEAR_STATS_EN.
module line_clear_sequencer #(
    parameter int COLS = 10,
    parameter int ROWS = 20,
    parameter int AW   = 8,
    parameter int DW   = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [4:0]    lines_cleared,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
`ifdef LINE_CLEAR_STATS_EN
    ,
    input  logic          stats_clr,
    output logic [15:0]   total_lines
`endif
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS + 1);

    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
    localparam logic [CW-1:0] COL_END   = CW'(COLS);
    localparam logic [4:0]    LINES_MAX = 5'(ROWS);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        SHIFT_RD,
        SHIFT_WR,
        ZERO_TOP,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [RW-1:0] dst_q, dst_d;
    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] c_q, c_d;
    logic          chk_q, chk_d;
    logic [4:0]    lines_q, lines_d;

    function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] r, input logic [CW-1:0] c);
        return AW'(r) * AW'(COLS) + AW'(c);
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            row_q   <= '0;
            dst_q   <= '0;
            col_q   <= '0;
            c_q     <= '0;
            chk_q   <= 1'b0;
            lines_q <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            dst_q   <= dst_d;
            col_q   <= col_d;
            c_q     <= c_d;
            chk_q   <= chk_d;
            lines_q <= lines_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        dst_d     = dst_q;
        col_d     = col_q;
        c_d       = c_q;
        chk_d     = chk_q;
        lines_d   = lines_q;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    row_d   = ROW_LAST;
                    col_d   = '0;
                    chk_d   = 1'b0;
                    lines_d = '0;
                    state_d = SCAN;
                end
            end

            SCAN: begin
                // col_q is the next cell to present; chk_q means col_q-1 is returning on mem_rdata now
                mem_addr = cell_addr(row_q, (col_q == COL_END) ? COL_LAST : col_q);
                if (chk_q && mem_rdata == '0) begin
                    chk_d = 1'b0;
                    col_d = '0;
                    if (row_q == '0) begin
                        state_d = DONE;
                    end else begin
                        row_d = row_q - RW'(1);
                    end
                end else if (chk_q && col_q == COL_END) begin
                    lines_d = (lines_q == LINES_MAX) ? lines_q : lines_q + 5'd1;
                    dst_d   = row_q;
                    c_d     = '0;
                    chk_d   = 1'b0;
                    col_d   = '0;
                    state_d = (row_q == '0) ? ZERO_TOP : SHIFT_RD;
                end else begin
                    col_d = col_q + CW'(1);
                    chk_d = 1'b1;
                end
            end

            SHIFT_RD: begin
                mem_addr = cell_addr(dst_q - RW'(1), c_q);
                state_d  = SHIFT_WR;
            end

            SHIFT_WR: begin
                mem_addr  = cell_addr(dst_q, c_q);
                mem_wdata = mem_rdata;
                mem_we    = 1'b1;
                if (c_q == COL_LAST) begin
                    c_d     = '0;
                    dst_d   = dst_q - RW'(1);
                    state_d = (dst_q == RW'(1)) ? ZERO_TOP : SHIFT_RD;
                end else begin
                    c_d     = c_q + CW'(1);
                    state_d = SHIFT_RD;
                end
            end

            ZERO_TOP: begin
                mem_addr = cell_addr('0, c_q);
                mem_we   = 1'b1;
                if (c_q == COL_LAST) begin
                    // the row that slid into row_q has not been checked yet
                    c_d     = '0;
                    col_d   = '0;
                    chk_d   = 1'b0;
                    state_d = SCAN;
                end else begin
                    c_d = c_q + CW'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign lines_cleared = lines_q;

`ifdef LINE_CLEAR_STATS_EN
    logic [15:0] total_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            total_q <= '0;
        end else if (stats_clr) begin
            total_q <= '0;
        end else if (state_q == DONE) begin
            total_q <= total_q + 16'(lines_q);
        end
    end

    assign total_lines = total_q;
`endif

endmodule
